// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete out of order, retire from head.
// Optional ROB_PERF_EN adds a 32-bit retired-instruction counter (commit_cnt).
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 6,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    input  logic [TAG_W-1:0] alloc_tag_new,
    input  logic [TAG_W-1:0] alloc_tag_old,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             cmpl_valid,
    input  logic [IDX_W-1:0] cmpl_idx,
    input  logic             flush,
    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [TAG_W-1:0] commit_tag_new,
    output logic [TAG_W-1:0] commit_tag_old,
    output logic [IDX_W:0]   count
`ifdef ROB_PERF_EN
    ,
    output logic [31:0]      commit_cnt
`endif
);

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [4:0]       rd_q      [DEPTH];
    logic [TAG_W-1:0] tag_new_q [DEPTH];
    logic [TAG_W-1:0] tag_old_q [DEPTH];
    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;
    logic [IDX_W:0]   count_q;
    logic             alloc_fire;
    logic             empty;

    assign empty        = (count_q == '0);
    assign alloc_ready  = (count_q != FULL_COUNT);
    assign alloc_fire   = alloc_valid && alloc_ready && !flush;
    assign alloc_idx    = tail_q;
    assign count        = count_q;
    assign commit_valid = valid_q[head_q] && done_q[head_q] && !flush;

    // Fields read as zero when empty so stale entries never leak to the free list.
    assign commit_rd      = empty ? '0 : rd_q[head_q];
    assign commit_tag_new = empty ? '0 : tag_new_q[head_q];
    assign commit_tag_old = empty ? '0 : tag_old_q[head_q];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Completion looks at current valid bits, so a same-cycle alloc is not yet completable.
            if (cmpl_valid && valid_q[cmpl_idx]) begin
                done_q[cmpl_idx] <= 1'b1;
            end
            if (commit_valid) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + IDX_W'(1);
            end
            if (alloc_fire) begin
                valid_q[tail_q]   <= 1'b1;
                done_q[tail_q]    <= 1'b0;
                rd_q[tail_q]      <= alloc_rd;
                tag_new_q[tail_q] <= alloc_tag_new;
                tag_old_q[tail_q] <= alloc_tag_old;
                tail_q            <= tail_q + IDX_W'(1);
            end
            count_q <= count_q + {{IDX_W{1'b0}}, alloc_fire}
                               - {{IDX_W{1'b0}}, commit_valid};
        end
    end

`ifdef ROB_PERF_EN
    // Survives flush on purpose: it tracks architectural retirement over the whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_cnt <= '0;
        end else if (commit_valid) begin
            commit_cnt <= commit_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reorder_buffer;

    localparam int DEPTH = 16;
    localparam int TAG_W = 6;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_valid;
    logic [4:0]       alloc_rd;
    logic [TAG_W-1:0] alloc_tag_new;
    logic [TAG_W-1:0] alloc_tag_old;
    logic             alloc_ready;
    logic [IDX_W-1:0] alloc_idx;
    logic             cmpl_valid;
    logic [IDX_W-1:0] cmpl_idx;
    logic             flush;
    logic             commit_valid;
    logic [4:0]       commit_rd;
    logic [TAG_W-1:0] commit_tag_new;
    logic [TAG_W-1:0] commit_tag_old;
    logic [IDX_W:0]   count;
`ifdef ROB_PERF_EN
    logic [31:0]      commit_cnt;
`endif

    always #5 clk = ~clk;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_rd       (alloc_rd),
        .alloc_tag_new  (alloc_tag_new),
        .alloc_tag_old  (alloc_tag_old),
        .alloc_ready    (alloc_ready),
        .alloc_idx      (alloc_idx),
        .cmpl_valid     (cmpl_valid),
        .cmpl_idx       (cmpl_idx),
        .flush          (flush),
        .commit_valid   (commit_valid),
        .commit_rd      (commit_rd),
        .commit_tag_new (commit_tag_new),
        .commit_tag_old (commit_tag_old),
        .count          (count)
`ifdef ROB_PERF_EN
        ,
        .commit_cnt     (commit_cnt)
`endif
    );

    typedef struct {
        logic [4:0]       rd;
        logic [TAG_W-1:0] tn;
        logic [TAG_W-1:0] to;
        bit               done;
    } ent_t;

    ent_t        q[$];
    int          m_head = 0;
    int unsigned m_perf = 0;
    bit          m_known = 0;

    int n_checks = 0;
    int n_errors = 0;

    // Pre-edge samples of the last step, used by directed literal checks.
    logic             s_cv;
    logic             s_ready;
    logic [IDX_W-1:0] s_idx;
    logic [IDX_W:0]   s_count;
    logic [TAG_W-1:0] s_old;
    logic [4:0]       s_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit fl, input bit av, input logic [4:0] rd,
                        input logic [TAG_W-1:0] tn, input logic [TAG_W-1:0] to,
                        input bit cv, input logic [IDX_W-1:0] ci);
        int sz;
        bit e_cv;
        bit e_ready;
        int pos;
        @(negedge clk);
        rst = r; flush = fl; alloc_valid = av; alloc_rd = rd;
        alloc_tag_new = tn; alloc_tag_old = to; cmpl_valid = cv; cmpl_idx = ci;
        #1;
        sz      = q.size();
        e_ready = (sz != DEPTH);
        e_cv    = (sz > 0) && q[0].done && !fl;
        if (m_known) begin
            chk("count", 32'(count), 32'(sz));
            chk("alloc_ready", 32'(alloc_ready), 32'(e_ready));
            chk("alloc_idx", 32'(alloc_idx), 32'((m_head + sz) % DEPTH));
            chk("commit_valid", 32'(commit_valid), 32'(e_cv));
            chk("commit_rd", 32'(commit_rd), sz > 0 ? 32'(q[0].rd) : 32'd0);
            chk("commit_tag_new", 32'(commit_tag_new), sz > 0 ? 32'(q[0].tn) : 32'd0);
            chk("commit_tag_old", 32'(commit_tag_old), sz > 0 ? 32'(q[0].to) : 32'd0);
`ifdef ROB_PERF_EN
            chk("commit_cnt", commit_cnt, m_perf);
`endif
        end
        s_cv = commit_valid; s_ready = alloc_ready; s_idx = alloc_idx;
        s_count = count; s_old = commit_tag_old; s_rd = commit_rd;
        @(posedge clk);
        if (r) begin
            q.delete(); m_head = 0; m_perf = 0; m_known = 1;
        end else if (fl) begin
            q.delete(); m_head = 0;
        end else begin
            if (cv) begin
                pos = (int'(ci) - m_head + DEPTH) % DEPTH;
                if (pos < sz) q[pos].done = 1;
            end
            if (e_cv) begin
                void'(q.pop_front());
                m_head = (m_head + 1) % DEPTH;
                m_perf++;
            end
            if (av && e_ready) q.push_back('{rd: rd, tn: tn, to: to, done: 1'b0});
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 5'd0, '0, '0, 0, '0);
    endtask
    task automatic alloc(input logic [4:0] rd, input logic [TAG_W-1:0] tn, input logic [TAG_W-1:0] to);
        step(0, 0, 1, rd, tn, to, 0, '0);
    endtask
    task automatic cmpl(input logic [IDX_W-1:0] ci);
        step(0, 0, 0, 5'd0, '0, '0, 1, ci);
    endtask
    task automatic do_flush();
        step(0, 1, 0, 5'd0, '0, '0, 0, '0);
    endtask

    initial begin
        int sz;
        logic [IDX_W-1:0] ci;
        step(1, 0, 0, 5'd0, '0, '0, 0, '0);
        step(1, 0, 0, 5'd0, '0, '0, 0, '0);
        idle();
        chk("rst_count", 32'(s_count), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_idx", 32'(s_idx), 32'd0);
        chk("rst_cv", 32'(s_cv), 32'd0);
        chk("rst_old", 32'(s_old), 32'd0);

        // Retire 10, then flush: counter must keep 10.
        for (int i = 0; i < 10; i++) alloc(5'(i + 1), 6'(i + 40), 6'(i));
        for (int i = 0; i < 10; i++) cmpl(4'(i));
        for (int i = 0; i < 3; i++) idle();
        do_flush();
        idle();
`ifdef ROB_PERF_EN
        chk("perf_after_flush", commit_cnt, 32'd10);
`endif
        chk("perf_flush_count", 32'(s_count), 32'd0);

        // Out-of-order completion, in-order retirement.
        alloc(5'd2, 6'd33, 6'd2);
        alloc(5'd3, 6'd34, 6'd3);
        cmpl(4'd1);
        idle();
        chk("ooo_no_commit", 32'(s_cv), 32'd0);
        cmpl(4'd0);
        idle();
        chk("ooo_first_cv", 32'(s_cv), 32'd1);
        chk("ooo_first_old", 32'(s_old), 32'd2);
        idle();
        chk("ooo_second_cv", 32'(s_cv), 32'd1);
        chk("ooo_second_old", 32'(s_old), 32'd3);
        idle();
        chk("ooo_empty", 32'(s_count), 32'd0);

        // Fill to full, 17th alloc refused.
        do_flush();
        for (int i = 0; i < 16; i++) alloc(5'(i), 6'(i), 6'(i + 16));
        alloc(5'd31, 6'd63, 6'd63);
        chk("full_ready", 32'(s_ready), 32'd0);
        chk("full_count", 32'(s_count), 32'd16);
        idle();
        chk("full_no_write", 32'(s_count), 32'd16);

        // Full with head done: commit happens, alloc waits a cycle, tail wraps to 0.
        step(0, 0, 1, 5'd9, 6'd50, 6'd51, 1, 4'd0);
        alloc(5'd9, 6'd50, 6'd51);
        chk("full_commit_cv", 32'(s_cv), 32'd1);
        chk("full_commit_ready", 32'(s_ready), 32'd0);
        alloc(5'd9, 6'd50, 6'd51);
        chk("wrap_count", 32'(s_count), 32'd15);
        chk("wrap_ready", 32'(s_ready), 32'd1);
        chk("wrap_idx", 32'(s_idx), 32'd0);
        idle();
        chk("wrap_refill", 32'(s_count), 32'd16);
        chk("wrap_tail", 32'(s_idx), 32'd1);

        // Complete while empty is a no-op.
        do_flush();
        cmpl(4'd5);
        idle();
        chk("empty_cmpl_cv", 32'(s_cv), 32'd0);
        chk("empty_cmpl_count", 32'(s_count), 32'd0);

        // Eight in flight, three done, flush.
        for (int i = 0; i < 8; i++) alloc(5'(i + 4), 6'(i + 8), 6'(i + 20));
        cmpl(4'd2);
        cmpl(4'd1);
        cmpl(4'd0);
        do_flush();
        chk("flush_no_commit", 32'(s_cv), 32'd0);
        idle();
        chk("flush_count", 32'(s_count), 32'd0);
        chk("flush_idx", 32'(s_idx), 32'd0);

        // Randomized traffic, including mid-stream reset and flush.
        for (int c = 0; c < 3000; c++) begin
            sz = q.size();
            if (sz > 0 && ($urandom % 4) != 0) ci = 4'((m_head + int'($urandom % sz)) % DEPTH);
            else ci = 4'($urandom % DEPTH);
            step(($urandom % 200) == 0, ($urandom % 60) == 0, ($urandom % 100) < 60,
                 5'($urandom), 6'($urandom), 6'($urandom), ($urandom % 100) < 55, ci);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement queue that sits directly downstream of `rename`. Each renamed instruction is allocated an entry holding its architectural destination, new physical tag and previous physical tag. Execution units mark entries complete out of order. The buffer retires completed entries strictly in program order, one per cycle, and returns the previous tag to the rename free list via the commit port.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, minimum 4
- `TAG_W`, 6, physical register tag width (64 physical registers)
- `IDX_W`, $clog2(DEPTH), entry index width (derived; do not override)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `alloc_valid`  in  1  renamed instruction presented for insertion
- `alloc_rd`  in  5  architectural destination register
- `alloc_tag_new`  in  TAG_W  physical tag assigned by rename
- `alloc_tag_old`  in  TAG_W  previous mapping of `alloc_rd`
- `alloc_ready`  out  1  buffer not full
- `alloc_idx`  out  IDX_W  index the presented instruction receives (equals tail pointer)
- `cmpl_valid`  in  1  execution result written back
- `cmpl_idx`  in  IDX_W  entry being completed
- `flush`  in  1  squash all entries
- `commit_valid`  out  1  head entry retires at this edge
- `commit_rd`  out  5  retiring architectural register
- `commit_tag_new`  out  TAG_W  retiring physical tag (now architectural)
- `commit_tag_old`  out  TAG_W  tag to release to the free list
- `count`  out  IDX_W+1  occupied entries

## Operation
- Circular array of DEPTH entries: `valid`, `done`, `rd`, `tag_new`, `tag_old`. Head and tail pointers are IDX_W bits wide and wrap modulo DEPTH. `count` distinguishes full from empty.
- Allocate: when `alloc_valid && alloc_ready`, write the entry at tail with `valid=1`, `done=0`, and the fields. Increment tail.
- `alloc_ready = (count != DEPTH)`. It depends only on state, with no bypass from a same-cycle commit.
- Complete: when `cmpl_valid`, set `done` at `cmpl_idx`. This is ignored if the entry is not valid. Re-completing a done entry has no effect.
- Commit: `commit_valid = valid[head] && done[head] && !flush`. When it is high, clear `valid[head]` and increment head. `commit_*` fields show the head entry contents whenever the buffer is not empty, and are 0 when it is empty.
- `count` next value is count + alloc − commit. A simultaneous alloc and commit leaves count unchanged.
- Flush has priority over allocate, complete and commit. All `valid` bits clear; head, tail and count return to 0.
- Entries with `alloc_rd == 0` are treated like any other entry. Filtering x0 is rename's responsibility.

## Timing
- Reset, and the cycle after flush: `alloc_ready=1`, `alloc_idx=0`, `commit_valid=0`, `commit_rd=0`, `commit_tag_new=0`, `commit_tag_old=0`, `count=0`.
- Allocate-to-visible: an entry allocated at edge N can be completed in the cycle after N.
- Complete-to-commit: completion captured at edge N gives `commit_valid` high in cycle N+1 (if the entry is at head) and retirement at edge N+1. Minimum latency from allocate to retire is 2 edges.
- Throughput: one allocate, one complete and one commit per cycle, in any combination.
- Alloc into an empty buffer and complete of the same index in the same cycle: the complete is ignored because the entry is not yet valid.
- Full with head done: the commit happens, but the alloc is refused that cycle. `alloc_ready` rises the next cycle.
- Wrap-around: tail and head roll from DEPTH−1 to 0 with no bubble.
- Reset asserted mid-stream discards all entries at that edge. Flush behaves identically.

## Configuration
- `ROB_PERF_EN` defined: adds output `commit_cnt` (32 bits), a count of retired instructions. It is cleared by `rst` only, not by `flush`, and wraps at 2^32.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then alloc rd=2/new=33/old=2 and rd=3/new=34/old=3, then complete idx 1 then idx 0. Required: no commit until idx 0 completes. Then commits occur in consecutive cycles: old=2, then old=3.
- Allocate 16 entries with no completes. Required: `alloc_ready=0`, `count=16`, and a 17th `alloc_valid` is not written.
- Full buffer, complete head, hold `alloc_valid`. Required: commit at the next edge, `count=15`, alloc accepted one cycle later with `alloc_idx=0`, and wrap correct.
- Complete idx 5 while the buffer is empty. Required: no state change and `commit_valid` stays 0.
- Eight entries in flight, three done, assert `flush`. Required: no commit that cycle, and next cycle `count=0` and `alloc_idx=0`.
- With `ROB_PERF_EN` defined, retire 10 instructions, then flush. Required: `commit_cnt=10` is retained after the flush.
